// File: rtl/i4001_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among up to eight i4001 requesters.
// One grant per edge; a requester granted at one edge is masked at the next one.
module i4001_rom_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [12*NUM_REQ-1:0]  req_addr,
  output logic [NUM_REQ-1:0]     ack,
  output logic [2:0]             rsp_id,
  output logic [7:0]             rsp_data,
  output logic [11:0]            rom_addr,
  input  logic [7:0]             rom_data
);

  logic [2:0]         r_last_grant;
  logic               r_inflight_valid;
  logic [2:0]         r_inflight_id;
  logic [11:0]        r_rom_addr;
  logic [NUM_REQ-1:0] r_ack;
  logic [2:0]         r_rsp_id;

  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_ack_next;
  logic               w_grant;
  logic [2:0]         w_winner;
  logic [11:0]        w_win_addr;
  logic [2:0]         w_last_grant_next;
  logic [2:0]         w_inflight_id_next;
  logic [11:0]        w_rom_addr_next;
  logic [2:0]         w_rsp_id_next;

  // Index reached by stepping k places past base, wrapping at NUM_REQ.
  // base < NUM_REQ and k <= NUM_REQ, so a single subtraction is enough.
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[2:0];
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_eligible[gi] = req[gi] & ~(r_inflight_valid & (r_inflight_id == 3'(gi)));
      assign w_ack_next[gi] = r_inflight_valid & (r_inflight_id == 3'(gi));
    end
  endgenerate

  always_comb begin
    w_grant    = 1'b0;
    w_winner   = r_last_grant;
    w_win_addr = r_rom_addr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant && w_eligible[i] && (rr_index(r_last_grant, k) == 3'(i))) begin
          w_grant    = 1'b1;
          w_winner   = 3'(i);
          w_win_addr = req_addr[12*i +: 12];
        end
      end
    end
  end

  // With no winner, address and pointer hold so the ROM keeps its last byte.
  always_comb begin
    w_last_grant_next  = r_last_grant;
    w_inflight_id_next = r_inflight_id;
    w_rom_addr_next    = r_rom_addr;
    w_rsp_id_next      = r_rsp_id;
    if (w_grant) begin
      w_last_grant_next  = w_winner;
      w_inflight_id_next = w_winner;
      w_rom_addr_next    = w_win_addr;
    end
    if (r_inflight_valid) w_rsp_id_next = r_inflight_id;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_last_grant     <= 3'(NUM_REQ - 1);
      r_inflight_valid <= 1'b0;
      r_inflight_id    <= 3'd0;
      r_rom_addr       <= 12'd0;
      r_ack            <= '0;
      r_rsp_id         <= 3'd0;
    end else begin
      r_last_grant     <= w_last_grant_next;
      r_inflight_valid <= w_grant;
      r_inflight_id    <= w_inflight_id_next;
      r_rom_addr       <= w_rom_addr_next;
      r_ack            <= w_ack_next;
      r_rsp_id         <= w_rsp_id_next;
    end
  end

  assign ack      = r_ack;
  assign rsp_id   = r_rsp_id;
  assign rom_addr = r_rom_addr;
  assign rsp_data = rom_data;

endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// Directed bench for i4001_rom_arbiter with a registered-read ROM holding addr[7:0]^A5.
module tb_i4001_rom_arbiter;

  localparam int N = 4;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [12*N-1:0] req_addr;
  logic [N-1:0]  ack;
  logic [2:0]    rsp_id;
  logic [7:0]    rsp_data;
  logic [11:0]   rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    mem [4096];

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  i4001_rom_arbiter #(.NUM_REQ(N)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .ack      (ack),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a) ^ 8'hA5;
  end

  always @(posedge sysclk) rom_data <= mem[rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] ack_e, input logic [2:0] id_e,
                         input logic [7:0] d_e);
    check({tag, ".ack"}, 32'(ack), 32'(ack_e));
    if (ack_e != 4'd0) begin
      check({tag, ".id"}, 32'(rsp_id), 32'(id_e));
      check({tag, ".data"}, 32'(rsp_data), 32'(d_e));
      $display("txn %s ack=%b id=%0d data=%02h", tag, ack, rsp_id, rsp_data);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [11:0] a);
    req[i] = v;
    req_addr[12*i +: 12] = a;
  endtask

  // Advance one rising edge, then sit on the falling edge for sampling/driving.
  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_addr = '0;
    step(); step();
    check("reset.ack", 32'(ack), 32'd0);
    check("reset.rsp_id", 32'(rsp_id), 32'd0);
    check("reset.rom_addr", 32'(rom_addr), 32'd0);

    // Single access after reset
    reset = 1'b0;
    set_req(2, 1'b1, 12'h013);
    step();
    chk_rsp("single.wait", 4'b0000, 3'd0, 8'h00);
    check("single.rom_addr", 32'(rom_addr), 32'h013);
    step();
    chk_rsp("single.ack", 4'b0100, 3'd2, 8'hB6);
    set_req(2, 1'b0, 12'h013);
    step();
    chk_rsp("single.after", 4'b0000, 3'd0, 8'h00);

    // In-flight mask: lone requester re-requests across its ack
    set_req(1, 1'b1, 12'h100);
    step();
    chk_rsp("mask.g1", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("mask.a1", 4'b0010, 3'd1, 8'hA5);
    set_req(1, 1'b1, 12'h101);
    step();
    chk_rsp("mask.gap", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("mask.a2", 4'b0010, 3'd1, 8'hA4);
    set_req(1, 1'b0, 12'h101);
    step();
    chk_rsp("mask.after", 4'b0000, 3'd0, 8'h00);

    // Full contention from reset: 0,1,2,3,0,1,2,3
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 12'h000);
    set_req(1, 1'b1, 12'h001);
    set_req(2, 1'b1, 12'h002);
    set_req(3, 1'b1, 12'h003);
    step();
    chk_rsp("full.first", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("full.r0", 4'b0001, 3'd0, 8'hA5);
    step();
    chk_rsp("full.r1", 4'b0010, 3'd1, 8'hA4);
    step();
    chk_rsp("full.r2", 4'b0100, 3'd2, 8'hA7);
    step();
    chk_rsp("full.r3", 4'b1000, 3'd3, 8'hA6);
    step();
    chk_rsp("full.r0b", 4'b0001, 3'd0, 8'hA5);
    req[0] = 1'b0;
    step();
    chk_rsp("full.r1b", 4'b0010, 3'd1, 8'hA4);
    req[1] = 1'b0;
    step();
    chk_rsp("full.r2b", 4'b0100, 3'd2, 8'hA7);
    req[2] = 1'b0;
    step();
    chk_rsp("full.r3b", 4'b1000, 3'd3, 8'hA6);
    req[3] = 1'b0;
    step();
    chk_rsp("full.idle", 4'b0000, 3'd0, 8'h00);

    // Round-robin wrap: last grant is 3, requesters 1 and 3 together
    set_req(1, 1'b1, 12'h021);
    set_req(3, 1'b1, 12'h033);
    step();
    chk_rsp("wrap.grant", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("wrap.r1", 4'b0010, 3'd1, 8'h84);
    req[1] = 1'b0;
    step();
    chk_rsp("wrap.r3", 4'b1000, 3'd3, 8'h96);
    req[3] = 1'b0;
    step();
    chk_rsp("wrap.idle", 4'b0000, 3'd0, 8'h00);

    // Reset lands on the edge where requester 2's ack would rise
    set_req(0, 1'b1, 12'h040);
    set_req(2, 1'b1, 12'h052);
    step();
    chk_rsp("rst.grant0", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("rst.r0", 4'b0001, 3'd0, 8'hE5);
    reset = 1'b1;
    step();
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.rsp_id", 32'(rsp_id), 32'd0);
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    step();
    chk_rsp("rst.regrant", 4'b0000, 3'd0, 8'h00);
    step();
    chk_rsp("rst.r0b", 4'b0001, 3'd0, 8'hE5);
    req[0] = 1'b0;
    step();
    chk_rsp("rst.r2", 4'b0100, 3'd2, 8'hF7);
    req[2] = 1'b0;
    step();
    chk_rsp("rst.idle", 4'b0000, 3'd0, 8'h00);

    // Idle hold after an access to 12'hFFF
    set_req(0, 1'b1, 12'hFFF);
    step();
    step();
    chk_rsp("idle.acc", 4'b0001, 3'd0, 8'h5A);
    req[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle.rom_addr", 32'(rom_addr), 32'hFFF);
      check("idle.ack", 32'(ack), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
